// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage hazard controller: load-use interlock bubbles, redirect squash slots and
// saturating performance counters for bubbles and interlocks.
module fetch_hazard_ctrl #(
  parameter int unsigned LOAD_DELAY     = 1,
  parameter int unsigned REDIRECT_SLOTS = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [5:0]       decode_op,
  input  logic [5:0]       decode_rd,
  input  logic [5:0]       fetch_rs1,
  input  logic [5:0]       fetch_rs2,
  output logic             pc_stall,
  output logic             need_nop,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] interlock_count
);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StInterlock = 2'd1,
    StSquash    = 2'd2,
    StRsvd      = 2'd3
  } st_e;

  localparam logic [2:0] LoadCnt     = 3'(LOAD_DELAY - 1);
  localparam logic [2:0] RedirectCnt = 3'(REDIRECT_SLOTS - 1);

  st_e              state_q, state_d, cur_st;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] ilk_q, ilk_d;
  logic             is_load, load_use, ilk_inc;

  // Opcode 6'h22 sits inside the load range but never writes a register.
  assign is_load  = (decode_op[5:3] == 3'b100) && (decode_op != 6'h22);
  assign load_use = is_load && (decode_rd != 6'h00) &&
                    ((decode_rd == fetch_rs1) || (decode_rd == fetch_rs2));

  // While reset is held the outputs behave as if the FSM were already in RUN.
  assign cur_st = reset ? StRun : state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_stall = 1'b0;
    need_nop = 1'b0;
    ilk_inc  = 1'b0;

    if (stall) begin
      pc_stall = 1'b1;
      need_nop = 1'b1;
    end else if (redirect) begin
      need_nop = 1'b1;
      if (REDIRECT_SLOTS == 1) begin
        state_d = StRun;
        cnt_d   = 3'd0;
      end else begin
        state_d = StSquash;
        cnt_d   = RedirectCnt;
      end
    end else begin
      unique case (cur_st)
        StInterlock: begin
          pc_stall = 1'b1;
          need_nop = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = StRun;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        StSquash: begin
          need_nop = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = StRun;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        StRun: begin
          if (load_use) begin
            pc_stall = 1'b1;
            need_nop = 1'b1;
            ilk_inc  = 1'b1;
            if (LOAD_DELAY == 1) begin
              state_d = StRun;
              cnt_d   = 3'd0;
            end else begin
              state_d = StInterlock;
              cnt_d   = LoadCnt;
            end
          end else begin
            state_d = StRun;
          end
        end
        default: begin
          // Reserved encoding: RUN outputs, but always recover to RUN.
          if (load_use) begin
            pc_stall = 1'b1;
            need_nop = 1'b1;
            ilk_inc  = 1'b1;
          end
          state_d = StRun;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    ilk_d    = ilk_q;
    if (need_nop && !(&bubble_q)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
    if (ilk_inc && !(&ilk_q)) begin
      ilk_d = ilk_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      cnt_q    <= 3'd0;
      bubble_q <= '0;
      ilk_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bubble_q <= bubble_d;
      ilk_q    <= ilk_d;
    end
  end

  assign state           = state_q;
  assign bubble_count    = bubble_q;
  assign interlock_count = ilk_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Scoreboard bench for fetch_hazard_ctrl: two shared-input instances (LOAD_DELAY=1/REDIRECT_SLOTS=1/
// CNT_W=16 and LOAD_DELAY=3/REDIRECT_SLOTS=2/CNT_W=4) checked against hand-computed vectors.
module tb_fetch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [5:0]  decode_op, decode_rd, fetch_rs1, fetch_rs2;

  logic        ps_a, nn_a, ps_b, nn_b;
  logic [1:0]  st_a, st_b;
  logic [15:0] bc_a, ic_a;
  logic [3:0]  bc_b, ic_b;

  typedef struct {
    int          id;
    logic        ps;
    logic        nn;
    logic [1:0]  st;
    logic [15:0] bc;
    logic [15:0] ic;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  always #5 clk = ~clk;

  fetch_hazard_ctrl #(.LOAD_DELAY(1), .REDIRECT_SLOTS(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .decode_op(decode_op), .decode_rd(decode_rd), .fetch_rs1(fetch_rs1), .fetch_rs2(fetch_rs2),
    .pc_stall(ps_a), .need_nop(nn_a), .state(st_a), .bubble_count(bc_a),
    .interlock_count(ic_a)
  );

  fetch_hazard_ctrl #(.LOAD_DELAY(3), .REDIRECT_SLOTS(2), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .decode_op(decode_op), .decode_rd(decode_rd), .fetch_rs1(fetch_rs1), .fetch_rs2(fetch_rs2),
    .pc_stall(ps_b), .need_nop(nn_b), .state(st_b), .bubble_count(bc_b),
    .interlock_count(ic_b)
  );

  task automatic chk(input string name, input int id, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, id, act, exp);
    end
  endtask

  // Monitor: every cycle the DUTs present outputs; compare against the queued expectation.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      exp_t e;
      e = q_a.pop_front();
      chk("a.pc_stall", e.id, {15'd0, ps_a}, {15'd0, e.ps});
      chk("a.need_nop", e.id, {15'd0, nn_a}, {15'd0, e.nn});
      chk("a.state", e.id, {14'd0, st_a}, {14'd0, e.st});
      chk("a.bubble_count", e.id, bc_a, e.bc);
      chk("a.interlock_count", e.id, ic_a, e.ic);
    end
    if (q_b.size() > 0) begin
      exp_t e;
      e = q_b.pop_front();
      chk("b.pc_stall", e.id, {15'd0, ps_b}, {15'd0, e.ps});
      chk("b.need_nop", e.id, {15'd0, nn_b}, {15'd0, e.nn});
      chk("b.state", e.id, {14'd0, st_b}, {14'd0, e.st});
      chk("b.bubble_count", e.id, {12'd0, bc_b}, e.bc);
      chk("b.interlock_count", e.id, {12'd0, ic_b}, e.ic);
    end
  end

  // Drive one cycle of stimulus and queue the outputs expected before the next edge.
  task automatic step(input logic rst, input logic stl, input logic rdr,
                      input logic [5:0] op, input logic [5:0] rd,
                      input logic [5:0] r1, input logic [5:0] r2,
                      input logic pa, input logic na, input int sa, input int ba, input int ia,
                      input logic pb, input logic nb, input int sb, input int bb, input int ib);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    stall     = stl;
    redirect  = rdr;
    decode_op = op;
    decode_rd = rd;
    fetch_rs1 = r1;
    fetch_rs2 = r2;
    e.id = step_id;
    e.ps = pa; e.nn = na; e.st = 2'(sa); e.bc = 16'(ba); e.ic = 16'(ia);
    q_a.push_back(e);
    e.ps = pb; e.nn = nb; e.st = 2'(sb); e.bc = 16'(bb); e.ic = 16'(ib);
    q_b.push_back(e);
    step_id++;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0;
    decode_op = 6'h00; decode_rd = 6'h00; fetch_rs1 = 6'h00; fetch_rs2 = 6'h00;
    repeat (2) @(posedge clk);

    //   rst stl rdr op     rd     rs1    rs2      a: ps nn st bc ic   b: ps nn st bc ic
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // Load-use hazard: single bubble for a, three-cycle interlock for b
    step(0, 0, 0, 6'h23, 6'h05, 6'h05, 6'h00,  1, 1, 0, 0, 0,  1, 1, 0, 0, 0);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 1, 1,  1, 1, 1, 1, 1);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 1, 1,  1, 1, 1, 2, 1);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 1, 1,  0, 0, 0, 3, 1);
    // rd=0 and opcode 6'h22 never hazard
    step(0, 0, 0, 6'h23, 6'h00, 6'h00, 6'h00,  0, 0, 0, 1, 1,  0, 0, 0, 3, 1);
    step(0, 0, 0, 6'h22, 6'h05, 6'h05, 6'h05,  0, 0, 0, 1, 1,  0, 0, 0, 3, 1);
    // FPR f0 matching rs2 is a hazard; redirect then abandons b's interlock
    step(0, 0, 0, 6'h27, 6'h20, 6'h01, 6'h20,  1, 1, 0, 1, 1,  1, 1, 0, 3, 1);
    step(0, 0, 1, 6'h00, 6'h00, 6'h00, 6'h00,  0, 1, 0, 2, 2,  0, 1, 1, 4, 2);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 3, 2,  0, 1, 2, 5, 2);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 3, 2,  0, 0, 0, 6, 2);
    // Redirect together with load-use: redirect wins, no interlock counted
    step(0, 0, 1, 6'h23, 6'h05, 6'h05, 6'h00,  0, 1, 0, 3, 2,  0, 1, 0, 6, 2);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 4, 2,  0, 1, 2, 7, 2);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 4, 2,  0, 0, 0, 8, 2);
    // Stall for two cycles inside b's interlock: five bubbles total
    step(0, 0, 0, 6'h23, 6'h05, 6'h05, 6'h00,  1, 1, 0, 4, 2,  1, 1, 0, 8, 2);
    step(0, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00,  1, 1, 0, 5, 3,  1, 1, 1, 9, 3);
    step(0, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00,  1, 1, 0, 6, 3,  1, 1, 1, 10, 3);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 7, 3,  1, 1, 1, 11, 3);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 7, 3,  1, 1, 1, 12, 3);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 7, 3,  0, 0, 0, 13, 3);
    // Reset in the middle of an interlock
    step(0, 0, 0, 6'h23, 6'h05, 6'h05, 6'h00,  1, 1, 0, 7, 3,  1, 1, 0, 13, 3);
    step(1, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 8, 4,  0, 0, 1, 14, 4);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // Outputs during reset follow RUN with live inputs
    step(1, 0, 0, 6'h23, 6'h05, 6'h05, 6'h00,  1, 1, 0, 0, 0,  1, 1, 0, 0, 0);
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // 20 stall cycles: 4-bit bubble counter saturates at 15
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00,  1, 1, 0, k, 0,
           1, 1, 0, (k > 15) ? 15 : k, 0);
    end
    step(0, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00,  0, 0, 0, 20, 0,  0, 0, 0, 15, 0);

    begin
      int guard = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      n_checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d entries left, expected 0", q_a.size() + q_b.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_hazard_ctrl.md
FETCH_HAZARD_CTRL -- requirements
Module: fetch_hazard_ctrl

Interface
REQ-001 Parameter LOAD_DELAY, default 1: number of bubble cycles inserted on a load-use hazard; legal range 1..7.
REQ-002 Parameter REDIRECT_SLOTS, default 1: number of wrong-path fetch cycles squashed per redirect; legal range 1..7.
REQ-003 Parameter CNT_W, default 16: width of the performance counters.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  external pipeline hold (e.g. memory busy).
REQ-007 redirect  input  1  taken branch/jump resolved in decode this cycle.
REQ-008 decode_op  input  6  opcode currently in decode.
REQ-009 decode_rd  input  6  destination register in decode; MSB=1 selects FPR.
REQ-010 fetch_rs1, fetch_rs2  input  6 each  source registers of the fetched instruction; MSB=1 selects FPR.
REQ-011 pc_stall  output  1  hold the PC this cycle.
REQ-012 need_nop  output  1  replace the fetched instruction with NOP (op 6'h00, funct 6'h15) toward decode.
REQ-013 state  output  2  FSM state: RUN=0, INTERLOCK=1, SQUASH=2.
REQ-014 bubble_count  output  CNT_W  cycles with need_nop=1.
REQ-015 interlock_count  output  CNT_W  load-use hazards detected.

Function
REQ-016 The block SHALL treat decode_op as a load iff it is in 6'h20..6'h27, excluding 6'h22.
REQ-017 The block SHALL flag load_use when: load in decode; decode_rd != 6'h00; and decode_rd equals fetch_rs1 or fetch_rs2. FPR f0 (6'h20) is a valid match.
REQ-018 pc_stall and need_nop SHALL be combinational functions of the registered state and current inputs; state, down-counter and perf counters SHALL be registered.
REQ-019 Per-cycle priority SHALL be: stall > redirect > load_use > state default.
REQ-020 stall=1 in any state: pc_stall=1, need_nop=1; state, down-counter and interlock_count SHALL be frozen.
REQ-021 redirect=1 (stall=0) in any state: pc_stall=0, need_nop=1. If REDIRECT_SLOTS=1, next state SHALL be RUN. Otherwise, next state SHALL be SQUASH with the down-counter loaded to REDIRECT_SLOTS-1. Any interlock in progress SHALL be abandoned.
REQ-022 RUN with load_use (stall=0, redirect=0): pc_stall=1, need_nop=1, interlock_count increments. If LOAD_DELAY=1, next state SHALL be RUN. Otherwise, next state SHALL be INTERLOCK with the counter loaded to LOAD_DELAY-1.
REQ-023 RUN with no event: pc_stall=0, need_nop=0.
REQ-024 INTERLOCK (no stall/redirect): pc_stall=1, need_nop=1, counter decrements; at counter=1 the next state SHALL be RUN. load_use SHALL NOT be re-evaluated.
REQ-025 SQUASH (no stall/redirect): pc_stall=0, need_nop=1, counter decrements; at counter=1 the next state SHALL be RUN.
REQ-026 bubble_count SHALL increment on every cycle with need_nop=1, including stall cycles. Both counters SHALL saturate at all-ones and never wrap.
REQ-027 An unused state encoding (3) SHALL transition to RUN next cycle, with outputs as in RUN.

Reset
REQ-028 reset=1 at a clock edge SHALL force state=RUN, down-counter=0, bubble_count=0 and interlock_count=0. reset has priority over all inputs, including mid-INTERLOCK and mid-SQUASH.
REQ-029 While reset is asserted, pc_stall and need_nop SHALL evaluate as in RUN with the current inputs; the first post-reset cycle SHALL behave as RUN.

Verification
REQ-030 LOAD_DELAY=1: decode_op=6'h23, decode_rd=6'h05, fetch_rs1=6'h05 for one cycle -> pc_stall=1, need_nop=1 that cycle; state stays 0; interlock_count=1.
REQ-031 LOAD_DELAY=3, same hazard -> pc_stall=need_nop=1 for exactly 3 cycles; state sequence 0,1,1,0; bubble_count=3.
REQ-032 decode_rd=6'h00 matching fetch_rs2=6'h00 with a load; and decode_op=6'h22 matching -> no stall, counters unchanged.
REQ-033 REDIRECT_SLOTS=2: redirect together with load_use -> pc_stall=0 and need_nop=1 for 2 cycles, state 0->2->0, interlock_count unchanged.
REQ-034 LOAD_DELAY=3: stall=1 for 2 cycles in the middle of INTERLOCK -> total bubble cycles=5; counter frozen while stalled. Then reset in INTERLOCK -> state=0 and both counters=0 next cycle.
REQ-035 CNT_W=4: 20 consecutive stall cycles -> bubble_count saturates at 4'hF.
